// File: rtl/serial_parity_checker.sv
// Receive side of the serial parity link: collects DATA_W bits LSB first plus one
// parity bit, flags parity mismatches and keeps a saturating error count.
module serial_parity_checker #(
  parameter int DATA_W  = 8,
  parameter bit PAR_INV = 1'b1,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rn,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              par_err,
  output logic              data_valid,
  input  logic              data_ready,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  // state   | meaning
  // COLLECT | accepting data bits, idx = next bit position
  // PARITY  | accepting the parity bit
  // HOLD    | word and flag presented, waiting for data_ready
  typedef enum logic [1:0] {COLLECT, PARITY, HOLD} state_t;

  localparam int                IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   shreg;
  logic                run_par;
  logic                xfer;
  logic                mismatch;

  assign xfer     = bit_valid & bit_ready;
  assign mismatch = bit_in ^ run_par;

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    bit_ready  = 1'b0;
    data_valid = 1'b0;
    case (state)
      COLLECT: begin
        bit_ready = 1'b1;
        if (xfer && (idx == LAST_IDX)) state_nxt = PARITY;
      end
      PARITY: begin
        bit_ready = 1'b1;
        if (xfer) state_nxt = HOLD;
      end
      HOLD: begin
        data_valid = 1'b1;
        if (data_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      idx      <= '0;
      shreg    <= '0;
      run_par  <= PAR_INV;
      data_out <= '0;
      par_err  <= 1'b0;
    end else begin
      if (state == COLLECT && xfer) begin
        shreg[idx] <= bit_in;
        run_par    <= run_par ^ bit_in;
        idx        <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
      // Running parity is re-seeded here so the next frame starts clean.
      if (state == PARITY && xfer) begin
        data_out <= shreg;
        par_err  <= mismatch;
        run_par  <= PAR_INV;
      end
    end
  end

  always_ff @(posedge clk or negedge rn) begin
    if (!rn)
      err_cnt <= '0;
    else if (clr_cnt)
      err_cnt <= '0;
    else if (state == PARITY && xfer && mismatch && err_cnt != CNT_MAX)
      err_cnt <= err_cnt + 1'b1;
  end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: two instances (odd parity / 8-bit count and
// even parity / 2-bit count) share one bit stream; scoreboard queues per instance.
module tb_serial_parity_checker;

  logic       clk = 1'b0;
  logic       rn;
  logic       bit_in, bit_valid, data_ready, clr_cnt;
  logic       bit_ready_a, bit_ready_b;
  logic [7:0] data_out_a, data_out_b;
  logic       par_err_a, par_err_b, data_valid_a, data_valid_b;
  logic [7:0] err_cnt_a;
  logic [1:0] err_cnt_b;

  always #5 clk = ~clk;

  serial_parity_checker u_a (
    .clk(clk), .rn(rn), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready_a),
    .data_out(data_out_a), .par_err(par_err_a), .data_valid(data_valid_a),
    .data_ready(data_ready), .clr_cnt(clr_cnt), .err_cnt(err_cnt_a)
  );

  serial_parity_checker #(.DATA_W(8), .PAR_INV(1'b0), .CNT_W(2)) u_b (
    .clk(clk), .rn(rn), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready_b),
    .data_out(data_out_b), .par_err(par_err_b), .data_valid(data_valid_b),
    .data_ready(data_ready), .clr_cnt(clr_cnt), .err_cnt(err_cnt_b)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t qa[$], qb[$];
  exp_t cur_a, cur_b;
  logic pv_a, pv_b;
  int   checks = 0, errors = 0;
  int   ca = 0, cb = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rn) pv_a <= 1'b0;
    else begin
      pv_a <= data_valid_a;
      if (data_valid_a && !pv_a) begin
        chk("a_word_expected", int'(qa.size() != 0), 1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          chk("a_data", int'(data_out_a), int'(e.data));
          chk("a_par_err", int'(par_err_a), int'(e.err));
          chk("a_err_cnt", int'(err_cnt_a), int'(e.cnt));
          cur_a <= e;
        end
      end else if (data_valid_a && pv_a) begin
        chk("a_hold_data", int'(data_out_a), int'(cur_a.data));
        chk("a_hold_err", int'(par_err_a), int'(cur_a.err));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rn) pv_b <= 1'b0;
    else begin
      pv_b <= data_valid_b;
      if (data_valid_b && !pv_b) begin
        chk("b_word_expected", int'(qb.size() != 0), 1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          chk("b_data", int'(data_out_b), int'(e.data));
          chk("b_par_err", int'(par_err_b), int'(e.err));
          chk("b_err_cnt", int'(err_cnt_b), int'(e.cnt));
          cur_b <= e;
        end
      end else if (data_valid_b && pv_b) begin
        chk("b_hold_data", int'(data_out_b), int'(cur_b.data));
        chk("b_hold_err", int'(par_err_b), int'(cur_b.err));
      end
    end
  end

  task automatic send_bit(input logic b, input int gap);
    int g;
    bit_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bit_in    = b;
    bit_valid = 1'b1;
    g = 0;
    while (!bit_ready_a && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!bit_ready_a) chk("bit_ready_timeout", int'(bit_ready_a), 1);
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic clr, input logic ea, input logic eb);
    if (clr) ca = 0; else if (ea && ca < 255) ca++;
    if (clr) cb = 0; else if (eb && cb < 3) cb++;
    qa.push_back('{data: d, err: ea, cnt: 8'(ca)});
    qb.push_back('{data: d, err: eb, cnt: 8'(cb)});
  endtask

  // ea/eb: required parity-error flag for the odd-parity and even-parity instance
  task automatic send_frame(input logic [7:0] d, input logic p, input logic clr,
                            input logic ea, input logic eb, input int gmax);
    for (int i = 0; i < 8; i++) send_bit(d[i], $urandom_range(0, gmax));
    repeat ($urandom_range(0, gmax)) @(negedge clk);
    clr_cnt = clr;
    push(d, clr, ea, eb);
    send_bit(p, 0);
    clr_cnt = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((qa.size() != 0 || qb.size() != 0) && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("drain", qa.size() + qb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       p;
    rn = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; data_ready = 1'b1; clr_cnt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data_valid", int'(data_valid_a), 0);
    chk("rst_data_out", int'(data_out_a), 0);
    chk("rst_par_err", int'(par_err_a), 0);
    chk("rst_err_cnt", int'(err_cnt_a), 0);
    rn = 1'b1;
    @(negedge clk);
    chk("rst_bit_ready", int'(bit_ready_a), 1);

    // 0xA5 has four ones: odd parity wants 1, even parity wants 0
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    drain();
    chk("t1_err_cnt_a", int'(err_cnt_a), 0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    drain();
    chk("t2_err_cnt_a", int'(err_cnt_a), 1);

    // consumer stall: offered bits must not be taken while the word is held
    data_ready = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    bit_in = 1'b1; bit_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t3_bit_ready", int'(bit_ready_a), 0);
      chk("t3_data_valid", int'(data_valid_a), 1);
      chk("t3_data_out", int'(data_out_a), 8'h3C);
    end
    data_ready = 1'b1;
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    drain();

    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0; ca = 0; cb = 0;
    chk("t4_clr_a", int'(err_cnt_a), 0);
    chk("t4_clr_b", int'(err_cnt_b), 0);
    // 0x00 with parity 1 is bad for the even-parity instance only
    repeat (5) send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    drain();
    chk("t4_sat_b", int'(err_cnt_b), 3);
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    drain();
    chk("t4_clr_wins_b", int'(err_cnt_b), 0);

    for (int n = 0; n < 100; n++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      send_frame(d, p, 1'b0, p != ~^d, p != ^d, 3);
    end
    drain();

    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    rn = 1'b0; ca = 0; cb = 0;
    repeat (2) @(negedge clk);
    chk("t6_rst_err_cnt_a", int'(err_cnt_a), 0);
    chk("t6_rst_data_valid", int'(data_valid_a), 0);
    rn = 1'b1;
    @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    drain();
    repeat (5) @(negedge clk);
    chk("final_queues", qa.size() + qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
